// File: rtl/servo_dispense_ctrl_if.sv
// Purpose: request/status bundle between a dispense requester and the servo controller.
// Latency: none, wires only.
// Backpressure: none; the requester watches busy and done.
interface servo_dispense_ctrl_if;
    logic       start;
    logic [3:0] coins;
    logic       abort;
    logic [8:0] angle;
    logic       busy;
    logic       done;
    logic [3:0] dispensed;

    // Requester side: issues jobs and abort, observes servo command and status
    modport master (
        output start, coins, abort,
        input  angle, busy, done, dispensed
    );

    // Controller side
    modport slave (
        input  start, coins, abort,
        output angle, busy, done, dispensed
    );
endinterface

// File: rtl/servo_dispense_ctrl.sv
// Purpose: slew-limited servo sequencer pushing N coins (home->push->home per coin) with safe abort.
// Latency: start accepted on the first clk edge in IDLE; each step holds STEP_CYCLES, each end DWELL_CYCLES.
// Backpressure: start is ignored while busy; abort forces an orderly return to home.
module servo_dispense_ctrl #(
    parameter int STEP_CYCLES  = 200000,
    parameter int DWELL_CYCLES = 25000000,
    parameter int HOME_ANGLE   = 0,
    parameter int PUSH_ANGLE   = 90
) (
    input  logic                  clk,
    input  logic                  clr,
    servo_dispense_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RAMP_OUT   = 3'd1;
    localparam logic [2:0] S_DWELL_OUT  = 3'd2;
    localparam logic [2:0] S_RAMP_BACK  = 3'd3;
    localparam logic [2:0] S_DWELL_BACK = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    // Timers count down from N-1 to 0, so they only need to hold N-1.
    localparam int STEP_W  = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;
    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [STEP_W-1:0]  STEP_RELOAD  = STEP_W'(STEP_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL_CYCLES - 1);

    localparam logic [8:0] HOME_A = 9'(HOME_ANGLE);
    localparam logic [8:0] PUSH_A = 9'(PUSH_ANGLE);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [8:0]         angle_q;
    logic [STEP_W-1:0]  step_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [3:0]         target;
    logic [3:0]         disp_q;
    logic               abort_flag;

    logic [8:0] goal;
    logic       at_goal;
    logic       step_due;
    logic       dwell_due;
    logic       in_ramp;
    logic       active;
    logic       entering;

    // Goal is push while going out, home otherwise; direction comes from the compare,
    // so a push angle below home ramps downward without special casing.
    assign goal      = (state == S_RAMP_BACK) ? HOME_A : PUSH_A;
    assign at_goal   = (angle_q == goal);
    assign step_due  = (step_cnt == '0);
    assign dwell_due = (dwell_cnt == '0);
    assign in_ramp   = (state == S_RAMP_OUT) || (state == S_RAMP_BACK);
    assign active    = (state == S_RAMP_OUT) || (state == S_DWELL_OUT) ||
                       (state == S_RAMP_BACK) || (state == S_DWELL_BACK);
    assign entering  = (state_nxt != state);

    // Next-state decode; abort only cuts short the outbound half of a coin cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.coins != 4'd0) ? S_RAMP_OUT : S_DONE;
                end
            end
            S_RAMP_OUT: begin
                if (bus.abort) begin
                    state_nxt = S_RAMP_BACK;
                end else if (at_goal) begin
                    state_nxt = S_DWELL_OUT;
                end
            end
            S_DWELL_OUT: begin
                if (bus.abort || dwell_due) begin
                    state_nxt = S_RAMP_BACK;
                end
            end
            S_RAMP_BACK: begin
                if (at_goal) begin
                    state_nxt = S_DWELL_BACK;
                end
            end
            S_DWELL_BACK: begin
                if (dwell_due) begin
                    // Live abort counts too: it is being latched on this same edge.
                    if ((disp_q == target) || abort_flag || bus.abort) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RAMP_OUT;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Step and dwell timers: both reload on any state change, otherwise run in their own states
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            step_cnt  <= '0;
            dwell_cnt <= '0;
        end else if (entering) begin
            step_cnt  <= STEP_RELOAD;
            dwell_cnt <= DWELL_RELOAD;
        end else if (in_ramp) begin
            step_cnt  <= step_due ? STEP_RELOAD : step_cnt - 1'b1;
        end else if ((state == S_DWELL_OUT) || (state == S_DWELL_BACK)) begin
            dwell_cnt <= dwell_cnt - 1'b1;
        end
    end

    // Angle command: one degree toward the goal per expired step, never past it
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            angle_q <= HOME_A;
        end else if (in_ramp && !entering && step_due && !at_goal) begin
            angle_q <= (angle_q < goal) ? angle_q + 9'd1 : angle_q - 9'd1;
        end
    end

    // Job bookkeeping: target and count on accept, count on a completed push dwell
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            target <= 4'd0;
            disp_q <= 4'd0;
        end else if ((state == S_IDLE) && bus.start) begin
            target <= bus.coins;
            disp_q <= 4'd0;
        end else if ((state == S_DWELL_OUT) && dwell_due && !bus.abort &&
                     (disp_q != 4'd15)) begin
            disp_q <= disp_q + 4'd1;
        end
    end

    // Abort flag: set by abort in any motion state, cleared as the job returns to IDLE
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            abort_flag <= 1'b0;
        end else if (state_nxt == S_IDLE) begin
            abort_flag <= 1'b0;
        end else if (active && bus.abort) begin
            abort_flag <= 1'b1;
        end
    end

    assign bus.angle     = angle_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.dispensed = disp_q;

endmodule
